// File: rtl/steered_fifos_pkg.sv
`default_nettype none
// ============================================================================
// Module      : steered_fifos_pkg
// Description : Shared helpers for the steered FIFO egress block.
//               - clog2: constant-function ceiling log2 used to size
//                 pointers, occupancies and the destination index.
//               - slice_lsb: packing helper.
//                 Slice i of a flat bus starts at bit i*width, the same
//                 layout that arbitrated_fifos uses.
//               - sat_room: true when a saturating counter may still
//                 increment.
//                 Both the drop and the error counter use it.
// Revision    : 1.0 - initial release
// ============================================================================
package steered_fifos_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    // Counters are compared in a 32-bit domain so that one function serves
    // any counter width up to 32 bits.
    function automatic logic sat_room(input logic [31:0] val, input logic [31:0] max_val);
        return (val < max_val);
    endfunction

endpackage : steered_fifos_pkg
`default_nettype wire

// File: rtl/steered_fifo_slice.sv
`default_nettype none
// ============================================================================
// Module      : steered_fifo_slice
// Description : Single show-ahead FIFO of DEPTH entries.
//               The head word is presented combinationally from storage.
//               Ports:
//                 clk, rst   - clock; asynchronous active-low reset.
//                 wr_en      - write request, already qualified by the
//                              parent's acceptance logic.
//                 rd_en      - pop request.
//                              It is ignored while the FIFO is empty.
//                 data_in    - word to write.
//                 data_out   - head word.
//                              It is driven to 0 while the FIFO is empty.
//                 occupancy  - number of stored words (0..DEPTH).
//                 empty/full - derived from the registered occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module steered_fifo_slice
    import steered_fifos_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 8,
    localparam int AW      = clog2(DEPTH),
    localparam int OCC_WID = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic [OCC_WID-1:0] occupancy,
    output logic               empty,
    output logic               full
);

    localparam logic [OCC_WID-1:0] c_depth = OCC_WID'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [OCC_WID-1:0] r_occ;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == c_depth);

    // A pop on an empty FIFO is ignored even when a push arrives in the
    // same cycle: the new word is simply written.
    assign w_do_rd = rd_en & ~w_empty;
    // A write into a full FIFO is only legal alongside an effective pop.
    assign w_do_wr = wr_en & (~w_full | w_do_rd);

    // Storage is not reset; the head output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_occ <= r_occ + OCC_WID'(1);
                2'b01:   r_occ <= r_occ - OCC_WID'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign occupancy = r_occ;
    assign empty     = w_empty;
    assign full      = w_full;

endmodule : steered_fifo_slice
`default_nettype wire

// File: rtl/steered_fifos.sv
`default_nettype none
// ============================================================================
// Module      : steered_fifos
// Description : Steers one input stream into NUM_REQS show-ahead FIFOs.
//               The target FIFO is selected by a destination index, and
//               each FIFO is drained independently.
//               Ports:
//                 clk, rst        - clock; asynchronous active-low reset.
//                 push/dest/data_in
//                                 - input word, its valid and its
//                                   destination index.
//                 in_ready        - the FIFO selected by dest accepts a
//                                   push this cycle.
//                                   It is combinational from dest, full
//                                   and pop.
//                 pop             - per-FIFO pop request.
//                 empty/full      - per-FIFO flags.
//                 flat_data_out   - head word of FIFO i at slice i*WIDTH.
//                 flat_occupancy  - entry count of FIFO i at slice
//                                   i*OCC_WID.
//                 drop_cnt        - saturating count of pushes refused by a
//                                   full FIFO.
//                 err_cnt         - saturating count of pushes with
//                                   dest >= NUM_REQS.
// Revision    : 1.0 - initial release
// ============================================================================
module steered_fifos
    import steered_fifos_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 8,
    parameter  int CNT_WID  = 8,
    localparam int DEST_WID = (clog2(NUM_REQS) < 1) ? 1 : clog2(NUM_REQS),
    localparam int OCC_WID  = clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DEST_WID-1:0]          dest,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         in_ready,
    input  logic [NUM_REQS-1:0]          pop,
    output logic [NUM_REQS-1:0]          empty,
    output logic [NUM_REQS-1:0]          full,
    output logic [NUM_REQS*WIDTH-1:0]    flat_data_out,
    output logic [NUM_REQS*OCC_WID-1:0]  flat_occupancy,
    output logic [CNT_WID-1:0]           drop_cnt,
    output logic [CNT_WID-1:0]           err_cnt
);

    localparam logic [DEST_WID:0] c_num_reqs = (DEST_WID + 1)'(NUM_REQS);
    localparam logic [31:0]       c_cnt_max  = 32'((64'd1 << CNT_WID) - 64'd1);

    logic                w_dest_valid;
    logic [NUM_REQS-1:0] w_sel;
    logic [NUM_REQS-1:0] w_wr_en;
    logic                w_sel_full;
    logic                w_sel_pop;
    logic                w_drop;
    logic                w_err;

    // The extra MSB keeps the compare correct when NUM_REQS == 2**DEST_WID.
    assign w_dest_valid = ({1'b0, dest} < c_num_reqs);

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_fifo
            assign w_sel[i]   = w_dest_valid & (dest == DEST_WID'(i));
            assign w_wr_en[i] = push & w_sel[i] & (~full[i] | pop[i]);

            steered_fifo_slice #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_slice (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (w_wr_en[i]),
                .rd_en     (pop[i]),
                .data_in   (data_in),
                .data_out  (flat_data_out[slice_lsb(i, WIDTH) +: WIDTH]),
                .occupancy (flat_occupancy[slice_lsb(i, OCC_WID) +: OCC_WID]),
                .empty     (empty[i]),
                .full      (full[i])
            );
        end
    endgenerate

    // One-hot select, so OR-reduction picks the addressed FIFO's flags
    // without an out-of-range index when dest >= NUM_REQS.
    assign w_sel_full = |(w_sel & full);
    assign w_sel_pop  = |(w_sel & pop);
    assign in_ready   = w_dest_valid & (~w_sel_full | w_sel_pop);

    assign w_drop = push & w_dest_valid & ~in_ready;
    assign w_err  = push & ~w_dest_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (w_drop && sat_room(32'(drop_cnt), c_cnt_max)) begin
                drop_cnt <= drop_cnt + CNT_WID'(1);
            end
            if (w_err && sat_room(32'(err_cnt), c_cnt_max)) begin
                err_cnt <= err_cnt + CNT_WID'(1);
            end
        end
    end

endmodule : steered_fifos
`default_nettype wire

// File: tb/tb_steered_fifos.sv
`default_nettype none
// ============================================================================
// Module      : tb_steered_fifos
// Description : Self-checking bench for steered_fifos.
//               It drives a 4-destination instance against a queue-based
//               reference model.
//               It also drives a 3-destination instance for the
//               invalid-destination path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_steered_fifos;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 4-destination instance
    logic        push = 1'b0;
    logic [1:0]  dest = '0;
    logic [7:0]  data_in = '0;
    logic [3:0]  pop = '0;
    logic        in_ready;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [31:0] fdata;
    logic [15:0] focc;
    logic [7:0]  drop_cnt;
    logic [7:0]  err_cnt;

    // 3-destination instance
    logic        push3 = 1'b0;
    logic [1:0]  dest3 = '0;
    logic [7:0]  data3 = '0;
    logic [2:0]  pop3 = '0;
    logic        in_ready3;
    logic [2:0]  empty3;
    logic [2:0]  full3;
    logic [23:0] fdata3;
    logic [11:0] focc3;
    logic [7:0]  drop3;
    logic [7:0]  err3;

    steered_fifos #(.NUM_REQS(4), .WIDTH(8), .DEPTH(8), .CNT_WID(8)) u_dut4 (
        .clk(clk), .rst(rst), .push(push), .dest(dest), .data_in(data_in),
        .in_ready(in_ready), .pop(pop), .empty(empty), .full(full),
        .flat_data_out(fdata), .flat_occupancy(focc),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    steered_fifos #(.NUM_REQS(3), .WIDTH(8), .DEPTH(8), .CNT_WID(8)) u_dut3 (
        .clk(clk), .rst(rst), .push(push3), .dest(dest3), .data_in(data3),
        .in_ready(in_ready3), .pop(pop3), .empty(empty3), .full(full3),
        .flat_data_out(fdata3), .flat_occupancy(focc3),
        .drop_cnt(drop3), .err_cnt(err3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per FIFO plus the counters.
    logic [7:0] mq [4][$];
    int         m_drop = 0;
    int         m_err  = 0;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_drop = 0;
        m_err  = 0;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s empty[%0d]", tag, i), int'(empty[i]), int'(mq[i].size() == 0));
            chk($sformatf("%s full[%0d]", tag, i), int'(full[i]), int'(mq[i].size() == 8));
            chk($sformatf("%s occ[%0d]", tag, i), int'(focc[i*4 +: 4]), mq[i].size());
            if (mq[i].size() > 0)
                chk($sformatf("%s head[%0d]", tag, i), int'(fdata[i*8 +: 8]), int'(mq[i][0]));
        end
        chk($sformatf("%s drop_cnt", tag), int'(drop_cnt), m_drop);
        chk($sformatf("%s err_cnt", tag), int'(err_cnt), m_err);
    endtask

    // Entered just after a rising edge; applies one cycle of stimulus,
    // checks in_ready before the edge and all state after it.
    task automatic step(input bit p, input logic [1:0] d, input logic [7:0] dat,
                        input logic [3:0] pp, output bit rdy_obs);
        bit exp_rdy;
        bit acc;
        bit dp [4];
        int di;
        push = p; dest = d; data_in = dat; pop = pp;
        #1;
        di = int'(d);
        exp_rdy = (mq[di].size() < 8) || pp[di];
        rdy_obs = in_ready;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        for (int i = 0; i < 4; i++) dp[i] = pp[i] && (mq[i].size() > 0);
        acc = p && exp_rdy;
        for (int i = 0; i < 4; i++) if (dp[i]) void'(mq[i].pop_front());
        if (acc) mq[di].push_back(dat);
        else if (p) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        @(posedge clk);
        #1;
        push = 1'b0; pop = '0;
        compare_all("step");
    endtask

    typedef struct {
        bit         push;
        logic [1:0] dest;
        logic [7:0] data;
        logic [3:0] pop;
        bit         rdy;
        logic [3:0] empty;
        logic [15:0] occ;
    } vec_t;

    vec_t vecs [6];
    bit   rdy;

    initial begin
        vecs[0] = '{1'b1, 2'd2, 8'hA1, 4'b0000, 1'b1, 4'b1011, 16'h0100};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b1111, 16'h0000};
        vecs[2] = '{1'b1, 2'd3, 8'h66, 4'b0000, 1'b1, 4'b0111, 16'h1000};
        vecs[3] = '{1'b1, 2'd3, 8'h77, 4'b0000, 1'b1, 4'b0111, 16'h2000};
        vecs[4] = '{1'b1, 2'd1, 8'h55, 4'b1010, 1'b1, 4'b0101, 16'h1010};
        vecs[5] = '{1'b0, 2'd0, 8'h00, 4'b1010, 1'b1, 4'b1111, 16'h0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset empty", int'(empty), 4'hF);
        chk("reset full", int'(full), 0);
        chk("reset data", int'(fdata), 0);
        chk("reset occ", int'(focc), 0);
        chk("reset drop", int'(drop_cnt), 0);
        chk("reset err", int'(err_cnt), 0);
        chk("reset in_ready", int'(in_ready), 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors
        for (int v = 0; v < 6; v++) begin
            step(vecs[v].push, vecs[v].dest, vecs[v].data, vecs[v].pop, rdy);
            chk($sformatf("vec%0d in_ready", v), int'(rdy), int'(vecs[v].rdy));
            chk($sformatf("vec%0d empty", v), int'(empty), int'(vecs[v].empty));
            chk($sformatf("vec%0d occ", v), int'(focc), int'(vecs[v].occ));
            if (v == 0) chk("vec0 head2", int'(fdata[23:16]), 8'hA1);
        end

        // Invalid destination on the 3-destination instance
        push3 = 1'b1; dest3 = 2'd3; data3 = 8'hEE; pop3 = '0;
        #1;
        chk("d3 in_ready bad dest", int'(in_ready3), 0);
        @(posedge clk); #1;
        push3 = 1'b0;
        chk("d3 err_cnt", int'(err3), 1);
        chk("d3 empty", int'(empty3), 3'b111);
        chk("d3 occ", int'(focc3), 0);
        chk("d3 drop", int'(drop3), 0);
        push3 = 1'b1; dest3 = 2'd1; data3 = 8'h42;
        #1;
        chk("d3 in_ready good dest", int'(in_ready3), 1);
        @(posedge clk); #1;
        push3 = 1'b0;
        chk("d3 empty after push", int'(empty3), 3'b101);
        chk("d3 head1", int'(fdata3[15:8]), 8'h42);
        push3 = 1'b1; dest3 = 2'd3; data3 = 8'h13;
        @(posedge clk); #1;
        push3 = 1'b0;
        chk("d3 err_cnt 2", int'(err3), 2);
        chk("d3 occ1 untouched", int'(focc3[7:4]), 1);

        // Fill FIFO 0, overflow, push-with-pop on full
        for (int k = 0; k < 8; k++) step(1'b1, 2'd0, 8'(8'h10 + k), 4'b0000, rdy);
        chk("fill full[0]", int'(full[0]), 1);
        dest = 2'd0; push = 1'b0; pop = '0;
        #1;
        chk("fill in_ready dest0", int'(in_ready), 0);
        step(1'b1, 2'd0, 8'h99, 4'b0000, rdy);
        chk("overflow drop_cnt", int'(drop_cnt), 1);
        chk("overflow head", int'(fdata[7:0]), 8'h10);
        step(1'b1, 2'd0, 8'h18, 4'b0001, rdy);
        chk("full+pop in_ready", int'(rdy), 1);
        chk("full+pop head", int'(fdata[7:0]), 8'h11);
        chk("full+pop occ", int'(focc[3:0]), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain1 head %0d", k), int'(fdata[7:0]), 8'h11 + k);
            step(1'b0, 2'd0, 8'h00, 4'b0001, rdy);
        end
        chk("drain1 empty", int'(empty[0]), 1);
        // Second pass crosses the pointer wrap
        for (int k = 0; k < 8; k++) step(1'b1, 2'd0, 8'(8'h20 + k), 4'b0000, rdy);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain2 head %0d", k), int'(fdata[7:0]), 8'h20 + k);
            step(1'b0, 2'd0, 8'h00, 4'b0001, rdy);
        end
        chk("drain2 empty", int'(empty[0]), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                 4'($urandom & $urandom), rdy);
        end

        // Asynchronous reset in the middle of traffic
        step(1'b1, 2'd1, 8'h5A, 4'b0000, rdy);
        step(1'b1, 2'd2, 8'hA5, 4'b0000, rdy);
        push = 1'b1; dest = 2'd0; data_in = 8'h33;
        #2;
        rst = 1'b0;
        #1;
        chk("async rst empty", int'(empty), 4'hF);
        chk("async rst full", int'(full), 0);
        chk("async rst occ", int'(focc), 0);
        chk("async rst drop", int'(drop_cnt), 0);
        chk("async rst err", int'(err_cnt), 0);
        chk("async rst d3 empty", int'(empty3), 3'b111);
        chk("async rst d3 err", int'(err3), 0);
        push = 1'b0;
        model_clear();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Drop counter saturation
        for (int k = 0; k < 8; k++) step(1'b1, 2'd0, 8'(k), 4'b0000, rdy);
        for (int k = 0; k < 300; k++) step(1'b1, 2'd0, 8'(k), 4'b0000, rdy);
        chk("drop_cnt saturated", int'(drop_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_steered_fifos
`default_nettype wire
